// File: rtl/serial_comp_pkg.sv
// Shared definitions for the serial two's-complement arbiter slice.
// Holds the controller state encoding and the default word width and
// requester count used by serial_comp_arbiter and serial_twos_core.
package serial_comp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/serial_twos_core.sv
// Bit-serial two's-complement core.
// The word is shifted out LSB first. Bits pass through unchanged up to and
// including the first 1, and every later bit is inverted. 'seen' records
// whether a 1 has already gone past.
// Ports:
//   Clock    rising-edge clock
//   reset_b  asynchronous active-low reset
//   load     capture data_in and clear the seen-one flag
//   shift    shift the word right by one bit
//   data_in  parallel word to complement
//   y        serial output bit (current LSB XOR seen)
module serial_twos_core
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             Clock,
    input  logic             reset_b,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             y
);

    logic [WIDTH-1:0] sr;
    logic             seen;

    always_ff @(posedge Clock or negedge reset_b) begin
        if (!reset_b) begin
            sr   <= '0;
            seen <= 1'b0;
        end else if (load) begin
            sr   <= data_in;
            seen <= 1'b0;
        end else if (shift) begin
            sr   <= {1'b0, sr[WIDTH-1:1]};
            seen <= seen | sr[0];
        end
    end

    assign y = sr[0] ^ seen;

endmodule

// File: rtl/serial_comp_arbiter.sv
// Round-robin front end for a shared bit-serial two's-complement core.
// One requester is granted, its word is latched, and the core is run through
// one load cycle and WIDTH shift cycles. The serial output is reassembled
// into a parallel result, which is returned with a one-cycle done pulse.
// Ports:
//   Clock     rising-edge clock
//   reset_b   asynchronous active-low reset
//   req       per-requester request level
//   req_data  requester i word at bits [i*WIDTH +: WIDTH]
//   gnt       one-hot grant, one-cycle pulse
//   busy      high whenever the controller is not idle
//   done      one-cycle pulse, result valid
//   done_id   id of the requester whose result is on result
//   result    two's complement of the granted word
//   ovf       granted word was the most-negative value
module serial_comp_arbiter
    import serial_comp_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     Clock,
    input  logic                     reset_b,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic [WIDTH-1:0]         result,
    output logic                     ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    id;
    logic [WIDTH-1:0]   word;
    logic [WIDTH-1:0]   result_sr;
    logic [CNT_W-1:0]   cnt;

    logic               found;
    logic [ID_W-1:0]    sel_id;
    logic [ID_W-1:0]    cand;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [WIDTH-1:0]   sel_word;
    logic [WIDTH-1:0]   assembled;
    logic               core_y;

    // Search from ptr+1 upward with wrap; the first set request wins.
    always_comb begin
        found      = 1'b0;
        sel_id     = '0;
        cand       = '0;
        sel_onehot = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % 32'(NUM_REQ));
            if (!found && req[cand]) begin
                found  = 1'b1;
                sel_id = cand;
            end
        end
        sel_onehot[sel_id] = 1'b1;
    end

    assign sel_word  = req_data[sel_id*WIDTH +: WIDTH];
    assign assembled = {core_y, result_sr[WIDTH-1:1]};

    serial_twos_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .Clock   (Clock),
        .reset_b (reset_b),
        .load    (state == LOAD),
        .shift   (state == SHIFT),
        .data_in (word),
        .y       (core_y)
    );

    always_ff @(posedge Clock or negedge reset_b) begin
        if (!reset_b) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            result    <= '0;
            ovf       <= 1'b0;
            ptr       <= ID_W'(NUM_REQ - 1);
            id        <= '0;
            word      <= '0;
            result_sr <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= sel_onehot;
                        word  <= sel_word;
                        id    <= sel_id;
                        ptr   <= sel_id;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    gnt   <= '0;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    result_sr <= assembled;
                    cnt       <= cnt + 1'b1;
                    // The last shift publishes the fully assembled word directly.
                    if (cnt == LAST_CNT) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        result  <= assembled;
                        done_id <= id;
                        ovf     <= (word == MOST_NEG);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comp_arbiter.sv
module tb_serial_comp_arbiter;

    typedef struct {
        logic [2:0] id;
        logic [7:0] res;
        logic       ovf;
    } exp_t;

    logic        Clock = 1'b0;
    logic        reset_b;

    // Instance A: 4 requesters, 8-bit words.
    logic [3:0]  req_a;
    logic [31:0] data_a;
    logic [3:0]  gnt_a;
    logic        busy_a, done_a, ovf_a;
    logic [1:0]  id_a;
    logic [7:0]  res_a;

    // Instance B: 2 requesters, 4-bit words.
    logic [1:0]  req_b;
    logic [7:0]  data_b;
    logic [1:0]  gnt_b;
    logic        busy_b, done_b, ovf_b;
    logic [0:0]  id_b;
    logic [3:0]  res_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gnt_cyc_a = 0;
    int gnt_cyc_b = 0;

    logic [3:0] exp_gnt_a[$];
    exp_t       exp_done_a[$];
    logic [1:0] exp_gnt_b[$];
    exp_t       exp_done_b[$];
    exp_t       ea, eb;

    serial_comp_arbiter #(
        .NUM_REQ(4),
        .WIDTH(8)
    ) dut_a (
        .Clock    (Clock),
        .reset_b  (reset_b),
        .req      (req_a),
        .req_data (data_a),
        .gnt      (gnt_a),
        .busy     (busy_a),
        .done     (done_a),
        .done_id  (id_a),
        .result   (res_a),
        .ovf      (ovf_a)
    );

    serial_comp_arbiter #(
        .NUM_REQ(2),
        .WIDTH(4)
    ) dut_b (
        .Clock    (Clock),
        .reset_b  (reset_b),
        .req      (req_b),
        .req_data (data_b),
        .gnt      (gnt_b),
        .busy     (busy_b),
        .done     (done_b),
        .done_id  (id_b),
        .result   (res_b),
        .ovf      (ovf_b)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor A: pops expected grants and results as the DUT presents them.
    always @(negedge Clock) begin
        if (gnt_a != '0) begin
            if (exp_gnt_a.size() == 0) check("gnt_a_unexpected", 32'(gnt_a), 32'h0);
            else check("gnt_a", 32'(gnt_a), 32'(exp_gnt_a.pop_front()));
            gnt_cyc_a = cyc;
        end
        if (done_a) begin
            if (exp_done_a.size() == 0) begin
                check("done_a_unexpected", 32'(done_a), 32'h0);
            end else begin
                ea = exp_done_a.pop_front();
                check("result_a", 32'(res_a), 32'(ea.res));
                check("done_id_a", 32'(id_a), 32'(ea.id));
                check("ovf_a", 32'(ovf_a), 32'(ea.ovf));
                check("latency_a", 32'(cyc - gnt_cyc_a), 32'd9);
            end
        end
    end

    // Monitor B.
    always @(negedge Clock) begin
        if (gnt_b != '0) begin
            if (exp_gnt_b.size() == 0) check("gnt_b_unexpected", 32'(gnt_b), 32'h0);
            else check("gnt_b", 32'(gnt_b), 32'(exp_gnt_b.pop_front()));
            gnt_cyc_b = cyc;
        end
        if (done_b) begin
            if (exp_done_b.size() == 0) begin
                check("done_b_unexpected", 32'(done_b), 32'h0);
            end else begin
                eb = exp_done_b.pop_front();
                check("result_b", 32'(res_b), 32'(eb.res));
                check("done_id_b", 32'(id_b), 32'(eb.id));
                check("ovf_b", 32'(ovf_b), 32'(eb.ovf));
                check("latency_b", 32'(cyc - gnt_cyc_b), 32'd5);
            end
        end
    end

    task automatic push_a(input logic [3:0] g, input logic [2:0] id, input logic [7:0] r, input logic o);
        exp_t e;
        e.id = id; e.res = r; e.ovf = o;
        exp_gnt_a.push_back(g);
        exp_done_a.push_back(e);
    endtask

    task automatic push_b(input logic [1:0] g, input logic [2:0] id, input logic [7:0] r, input logic o);
        exp_t e;
        e.id = id; e.res = r; e.ovf = o;
        exp_gnt_b.push_back(g);
        exp_done_b.push_back(e);
    endtask

    // Returns at the negedge where a grant is visible on instance A.
    task automatic wait_gnt_a(output int c);
        int n;
        n = 0;
        @(negedge Clock);
        while (gnt_a == '0 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (gnt_a == '0) begin
            checks++;
            failures++;
            $display("FAIL gnt_a_timeout actual=none required=grant");
        end
        c = cyc;
    endtask

    task automatic wait_gnt_b();
        int n;
        n = 0;
        @(negedge Clock);
        while (gnt_b == '0 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (gnt_b == '0) begin
            checks++;
            failures++;
            $display("FAIL gnt_b_timeout actual=none required=grant");
        end
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        repeat (2) @(negedge Clock);
        reset_b = 1'b1;
    endtask

    logic [7:0] vin[4]  = '{8'h00, 8'h80, 8'hFF, 8'h01};
    logic [7:0] vout[4] = '{8'h00, 8'h80, 8'h01, 8'hFF};
    logic       vovf[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int         seq4[7] = '{1, 3, 1, 3, 0, 1, 3};
    logic [7:0] res4[4] = '{8'h81, 8'hF0, 8'h00, 8'hD0};

    initial begin
        int c, prev, n;
        reset_b = 1'b0;
        req_a = '0; data_a = '0;
        req_b = '0; data_b = '0;
        @(negedge Clock);

        // Reset state.
        check("rst_gnt_a", 32'(gnt_a), 32'h0);
        check("rst_busy_a", 32'(busy_a), 32'h0);
        check("rst_done_a", 32'(done_a), 32'h0);
        check("rst_result_a", 32'(res_a), 32'h0);
        check("rst_done_id_a", 32'(id_a), 32'h0);
        check("rst_ovf_a", 32'(ovf_a), 32'h0);
        check("rst_busy_b", 32'(busy_b), 32'h0);
        @(negedge Clock);
        reset_b = 1'b1;
        @(negedge Clock);

        // 1. Single request with busy window.
        data_a[7:0] = 8'h05;
        req_a = 4'b0001;
        push_a(4'b0001, 3'd0, 8'hFB, 1'b0);
        wait_gnt_a(c);
        req_a = '0;
        check("busy_e0", 32'(busy_a), 32'h1);
        for (int j = 1; j <= 9; j++) begin
            @(negedge Clock);
            check("busy_mid", 32'(busy_a), 32'h1);
        end
        @(negedge Clock);
        check("busy_e10", 32'(busy_a), 32'h0);
        @(negedge Clock);

        // 2. Boundary values on req[2].
        for (int v = 0; v < 4; v++) begin
            data_a[23:16] = vin[v];
            req_a = 4'b0100;
            push_a(4'b0100, 3'd2, vout[v], vovf[v]);
            wait_gnt_a(c);
            req_a = '0;
            repeat (11) @(negedge Clock);
        end

        // 3. All four held from reset: grants 0,1,2,3, 11 cycles apart.
        data_a = 32'h44332211;
        req_a = 4'b1111;
        do_reset();
        push_a(4'b0001, 3'd0, 8'hEF, 1'b0);
        push_a(4'b0010, 3'd1, 8'hDE, 1'b0);
        push_a(4'b0100, 3'd2, 8'hCD, 1'b0);
        push_a(4'b1000, 3'd3, 8'hBC, 1'b0);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt_a(c);
            req_a = req_a & ~gnt_a;
            if (k > 0) check("gnt_spacing", 32'(c - prev), 32'd11);
            prev = c;
        end
        repeat (12) @(negedge Clock);

        // 4. req[1] and req[3] held; req[0] raised during req[3]'s turn.
        data_a = 32'h3000107F;
        req_a = 4'b1010;
        for (int k = 0; k < 7; k++)
            push_a(4'(1 << seq4[k]), 3'(seq4[k]), res4[seq4[k]], 1'b0);
        for (int k = 0; k < 7; k++) begin
            wait_gnt_a(c);
            if (k == 3) req_a[0] = 1'b1;
            if (k == 4) req_a[0] = 1'b0;
            if (k == 5) req_a[1] = 1'b0;
            if (k == 6) req_a[3] = 1'b0;
        end
        repeat (12) @(negedge Clock);

        // 5. Reset during the 4th shift cycle; pointer returns to NUM_REQ-1.
        data_a = 32'h40050000;
        req_a = 4'b0100;
        exp_gnt_a.push_back(4'b0100);
        wait_gnt_a(c);
        req_a = 4'b1100;
        repeat (4) @(negedge Clock);
        reset_b = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(gnt_a), 32'h0);
        check("mid_rst_busy", 32'(busy_a), 32'h0);
        check("mid_rst_done", 32'(done_a), 32'h0);
        check("mid_rst_result", 32'(res_a), 32'h0);
        check("mid_rst_done_id", 32'(id_a), 32'h0);
        check("mid_rst_ovf", 32'(ovf_a), 32'h0);
        repeat (2) @(negedge Clock);
        reset_b = 1'b1;
        push_a(4'b0100, 3'd2, 8'hFB, 1'b0);
        push_a(4'b1000, 3'd3, 8'hC0, 1'b0);
        wait_gnt_a(c);
        req_a[2] = 1'b0;
        wait_gnt_a(c);
        req_a[3] = 1'b0;
        repeat (12) @(negedge Clock);

        // 6. Narrow instance: WIDTH=4, NUM_REQ=2.
        data_b = 8'h60;
        req_b = 2'b10;
        push_b(2'b10, 3'd1, 8'hA, 1'b0);
        wait_gnt_b();
        req_b = '0;
        repeat (8) @(negedge Clock);
        data_b = 8'h08;
        req_b = 2'b01;
        push_b(2'b01, 3'd0, 8'h8, 1'b1);
        wait_gnt_b();
        req_b = '0;

        // Drain the scoreboards.
        n = 0;
        while ((exp_done_a.size() + exp_done_b.size() + exp_gnt_a.size() + exp_gnt_b.size()) != 0 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        check("pending_a", 32'(exp_done_a.size() + exp_gnt_a.size()), 32'h0);
        check("pending_b", 32'(exp_done_b.size() + exp_gnt_b.size()), 32'h0);
        repeat (3) @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_comp_arbiter.md
Name: serial_comp_arbiter

Overview:
Shares one bit-serial two's-complement datapath between NUM_REQ requesters. Round-robin arbitration picks one requester and latches its word. The block then sequences the datapath through one load cycle and WIDTH shift cycles, reassembles the serial output into a parallel result, and returns it with a one-cycle done pulse tagged with the requester id. It sits between the parallel-word producers and the serial complementer core it owns.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, data word width in bits (2..16)
ID_W, $clog2(NUM_REQ), width of requester id

Ports:
Clock  input  1  rising-edge clock
reset_b  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request level
req_data  input  NUM_REQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
gnt  output  NUM_REQ  one-hot grant, one-cycle pulse
busy  output  1  high whenever FSM not in IDLE
done  output  1  one-cycle pulse, result valid
done_id  output  ID_W  id of requester whose result is on result
result  output  WIDTH  two's complement of the granted word
ovf  output  1  granted word was 1000...0 (result equals input); valid with done

Behaviour:
- Reset (reset_b=0, asynchronous, active-low; clock Clock): state=IDLE; gnt, busy, done, done_id, result, ovf all 0. Round-robin pointer = NUM_REQ-1, so req[0] has top priority first. Core cleared. Reset mid-transaction abandons the word; no done is produced.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: if any req bit is set at edge E0, grant the first set bit searching from ptr+1 upward with wrap. At E0: gnt<=onehot(i), word<=req_data slice i, id<=i, ptr<=i, state<=LOAD. With no req, stay in IDLE and keep gnt=0.
- Handshake: requester holds req and req_data stable until it sees gnt[i]=1. Data is sampled at the edge that raises gnt. Requester may drop or re-raise req on the gnt cycle. Dropping req before a grant is legal and is simply not granted. Requests raised while busy wait.
- LOAD (edge E1): core load=1 captures word and clears the seen-one flag. gnt<=0. cnt<=0. state<=SHIFT.
- SHIFT (edges E2..E(WIDTH+1)): core shift=1 each cycle. Serial bit y = core_lsb XOR seen (combinational). At each shift edge: result_sr <= {y, result_sr[WIDTH-1:1]}; seen <= seen | core_lsb; core word shifts right. cnt increments. At cnt==WIDTH-1 the final shift happens and state<=DONE.
- At E(WIDTH+1): done<=1, result<=completed register, done_id<=id, ovf<=(word==1 followed by WIDTH-1 zeros).
- DONE (edge E(WIDTH+2)): done<=0, state<=IDLE. The next gnt can come at E(WIDTH+3) at the earliest, so throughput is one word per WIDTH+3 cycles.
- Latency: done rises WIDTH+1 edges after the edge that raised gnt (9 for WIDTH=8). result, done_id and ovf hold their values until the next done.
- Arithmetic: result = (~word + 1) mod 2^WIDTH. Input 0 gives 0. Most-negative input gives itself and sets ovf=1.
- busy=1 in LOAD, SHIFT and DONE.

Decomposition:
- Package serial_comp_pkg holds the state encoding constants (IDLE, LOAD, SHIFT, DONE) and the default WIDTH/NUM_REQ.
- Sub-module serial_twos_core is the WIDTH-bit shift register plus seen-one flag. Ports: Clock, reset_b, load, shift, data_in, y. The controller instantiates it once. Arbitration, counter and result assembly stay in serial_comp_arbiter.

Test Plan:
1. Single request: req[0]=1, data 8'h05 -> gnt=4'b0001 at E0; done at E9 with result=8'hFB, done_id=0, ovf=0; busy high from E0 through E10.
2. Boundary values on req[2]: 8'h00->8'h00 ovf=0; 8'h80->8'h80 ovf=1; 8'hFF->8'h01; 8'h01->8'hFF.
3. All four requests held from reset with data 11,22,33,44 (hex) -> grants in order 0,1,2,3 spaced 11 cycles apart; results EF,DE,CD,BC with matching done_id.
4. req[1] and req[3] held continuously -> grants alternate 1,3,1,3; req[0] raised mid-stream is granted right after the current holder's turn per pointer order.
5. reset_b pulled low during the 4th shift cycle -> all outputs 0 immediately with no edge; no done. After release a pending req[2] is granted first only if req[0] and req[1] are low (pointer reset).
6. WIDTH=4, NUM_REQ=2 instance, req[1] data 4'b0110 -> gnt=2'b10, done 5 edges later, result=4'b1010, done_id=1.
